// File: rtl/fft_pkg.sv
// Shared constants, types and width helpers for the FFT post-processing blocks.
package fft_pkg;

  localparam int W_DEF = 16;

  function automatic int mag_width(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int bin_w(input int n_bins);
    return (n_bins > 1) ? $clog2(n_bins) : 1;
  endfunction

  localparam int MAG_W_DEF = mag_width(W_DEF);

  typedef logic [MAG_W_DEF-1:0] mag_t;

endpackage

// File: rtl/fft_bin_counter.sv
// Wrapping bin counter for one FFT frame. It advances on en, and clr restarts the count at bin 0.
module fft_bin_counter
  import fft_pkg::*;
#(
  parameter int N_BINS = 16,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 7,
  localparam int BW = bin_w(N_BINS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [BW-1:0] bin,
  output logic          is_last,
  output logic          in_window
);

  logic [BW-1:0] cnt_q, cnt_d;

  // A clear takes effect in its own cycle, so a sample that arrives with it is bin 0.
  assign bin       = clr ? '0 : cnt_q;
  assign is_last   = (int'(bin) == N_BINS - 1);
  assign in_window = (int'(bin) >= BIN_LO) && (int'(bin) <= BIN_HI);

  always_comb begin
    cnt_d = bin;
    if (en) cnt_d = is_last ? '0 : bin + BW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame argmax of mag_sq over a bin window. It emits a one-cycle result after the last bin of each frame.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int N_BINS = 16,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 7,
  localparam int MW    = mag_width(W),
  localparam int BW    = bin_w(N_BINS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mag_valid,
  input  logic [MW-1:0] mag_sq,
  input  logic [MW-1:0] threshold,
  input  logic          frame_restart,
  output logic          peak_valid,
  output logic [BW-1:0] peak_bin,
  output logic [MW-1:0] peak_mag,
  output logic          peak_above
);

  logic [BW-1:0] bin;
  logic          is_last;
  logic          in_window;

  fft_bin_counter #(
    .N_BINS (N_BINS),
    .BIN_LO (BIN_LO),
    .BIN_HI (BIN_HI)
  ) u_bin_counter (
    .clk       (clk),
    .reset     (reset),
    .en        (mag_valid),
    .clr       (frame_restart),
    .bin       (bin),
    .is_last   (is_last),
    .in_window (in_window)
  );

  logic          full_q, full_d;
  logic [BW-1:0] trk_bin_q, trk_bin_d;
  logic [MW-1:0] trk_mag_q, trk_mag_d;
  logic          peak_valid_q, peak_valid_d;
  logic [BW-1:0] peak_bin_q, peak_bin_d;
  logic [MW-1:0] peak_mag_q, peak_mag_d;
  logic          peak_above_q, peak_above_d;

  logic          cand_full;
  logic [BW-1:0] cand_bin;
  logic [MW-1:0] cand_mag;

  // NOTE: every signal gets a default first, so no path through the block can infer a latch.
  always_comb begin
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_above_d = peak_above_q;

    // The candidate is the tracker after this cycle's sample. A restart discards the old frame first.
    cand_full = full_q && !frame_restart;
    cand_bin  = trk_bin_q;
    cand_mag  = trk_mag_q;
    if (mag_valid && in_window && (!cand_full || (mag_sq > cand_mag))) begin
      cand_full = 1'b1;
      cand_bin  = bin;
      cand_mag  = mag_sq;
    end

    full_d    = cand_full;
    trk_bin_d = cand_bin;
    trk_mag_d = cand_mag;

    if (mag_valid && is_last) begin
      peak_valid_d = 1'b1;
      peak_bin_d   = cand_bin;
      peak_mag_d   = cand_mag;
      peak_above_d = (cand_mag >= threshold);
      full_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q       <= 1'b0;
      trk_bin_q    <= '0;
      trk_mag_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_above_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      trk_bin_q    <= trk_bin_d;
      trk_mag_q    <= trk_mag_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_above_q <= peak_above_d;
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_above = peak_above_q;

endmodule
